// File: rtl/i2c_slave_responder.sv
// Pointer-based I2C slave with a DEPTH x 8 register file. SCL/SDA are oversampled on pclk,
// synchronised, glitch-filtered, and decoded into START/STOP and bit events.
module i2c_slave_responder #(
  parameter logic [6:0] SLAVE_ADDR     = 7'h50,
  parameter int         DEPTH          = 16,
  parameter int         FILT_LEN       = 3,
  parameter int         SDA_HOLD       = 2,
  parameter int         STRETCH_CYCLES = 0,
  localparam int        PTR_W          = $clog2(DEPTH)
) (
  input  logic             pclk,
  input  logic             areset,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             scl_oe,
  output logic             sda_oe,
  output logic             busy,
  output logic             reg_wr_en,
  output logic [PTR_W-1:0] reg_wr_addr,
  output logic [7:0]       reg_wr_data,
  output logic             ack_err,
  output logic [3:0]       dbg_state
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_t;

  localparam logic [15:0] STR_LOAD = 16'((STRETCH_CYCLES > 0) ? STRETCH_CYCLES - 1 : 0);
  localparam logic        STR_EN   = (STRETCH_CYCLES > 0);

  // Line index 1 = SCL, 0 = SDA throughout the front end.
  logic [1:0] sync1, sync2, filt, filt_q;
  logic [2:0] fcnt [2];

  always_ff @(posedge pclk) begin
    if (areset) begin
      sync1   <= 2'b11;
      sync2   <= 2'b11;
      filt    <= 2'b11;
      filt_q  <= 2'b11;
      fcnt[0] <= '0;
      fcnt[1] <= '0;
    end else begin
      sync1  <= {scl_i, sda_i};
      sync2  <= sync1;
      filt_q <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == 3'(FILT_LEN - 1)) begin
          filt[i] <= sync2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 3'd1;
        end
      end
    end
  end

  logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det;

  assign scl_f     = filt[1];
  assign sda_f     = filt[0];
  assign scl_rise  = filt[1] & ~filt_q[1];
  assign scl_fall  = ~filt[1] & filt_q[1];
  assign start_det = scl_f & filt_q[0] & ~filt[0];
  assign stop_det  = scl_f & ~filt_q[0] & filt[0];

  state_t             state;
  logic [7:0]         regs [DEPTH];
  logic [PTR_W-1:0]   ptr, ptr_nxt;
  logic               ptr_ok, rw;
  logic [6:0]         shift;
  logic [7:0]         rx_byte, tx_byte;
  logic               ptr_in_range;
  logic [2:0]         bit_cnt;
  logic               hold_act;
  logic [7:0]         hold_cnt;
  logic               str_pend;
  logic [15:0]        str_cnt;
  logic               nack_pend, nack_rise;
  logic               drive_val;

  assign ptr_nxt      = ptr + PTR_W'(1);
  assign rx_byte      = {shift, sda_f};
  assign ptr_in_range = ({1'b0, rx_byte} < 9'(DEPTH));
  assign dbg_state    = state;

  // Level SDA should take once the post-fall hold time expires; 1 = pull low.
  always_comb begin
    drive_val = 1'b0;
    case (state)
      ADDR_ACK, WDATA_ACK: drive_val = 1'b1;
      PTR_ACK:             drive_val = ptr_ok;
      RDATA:               drive_val = ~tx_byte[7];
      default:             drive_val = 1'b0;
    endcase
  end

  // reg_wr_en is a valid-only strobe: one cycle per accepted byte, no backpressure.
  always_ff @(posedge pclk) begin
    if (areset) begin
      state       <= IDLE;
      sda_oe      <= 1'b0;
      scl_oe      <= 1'b0;
      busy        <= 1'b0;
      reg_wr_en   <= 1'b0;
      reg_wr_addr <= '0;
      reg_wr_data <= '0;
      ack_err     <= 1'b0;
      ptr         <= '0;
      ptr_ok      <= 1'b0;
      rw          <= 1'b0;
      shift       <= '0;
      tx_byte     <= '0;
      bit_cnt     <= '0;
      hold_act    <= 1'b0;
      hold_cnt    <= '0;
      str_pend    <= 1'b0;
      str_cnt     <= '0;
      nack_pend   <= 1'b0;
      nack_rise   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      reg_wr_en <= 1'b0;
      ack_err   <= 1'b0;
      if (stop_det) begin
        state     <= IDLE;
        sda_oe    <= 1'b0;
        scl_oe    <= 1'b0;
        busy      <= 1'b0;
        bit_cnt   <= '0;
        hold_act  <= 1'b0;
        str_pend  <= 1'b0;
        nack_pend <= 1'b0;
        nack_rise <= 1'b0;
      end else if (start_det) begin
        state     <= ADDR;
        sda_oe    <= 1'b0;
        scl_oe    <= 1'b0;
        bit_cnt   <= '0;
        hold_act  <= 1'b0;
        str_pend  <= 1'b0;
        nack_pend <= 1'b0;
        nack_rise <= 1'b0;
      end else begin
        if (scl_fall) begin
          if (SDA_HOLD == 0) begin
            sda_oe <= drive_val;
          end else begin
            hold_act <= 1'b1;
            hold_cnt <= 8'(SDA_HOLD);
          end
        end else if (hold_act) begin
          if (hold_cnt <= 8'd1) begin
            sda_oe   <= drive_val;
            hold_act <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - 8'd1;
          end
        end

        if (scl_fall && str_pend) begin
          scl_oe   <= 1'b1;
          str_cnt  <= STR_LOAD;
          str_pend <= 1'b0;
        end else if (scl_oe) begin
          if (str_cnt == '0) scl_oe <= 1'b0;
          else               str_cnt <= str_cnt - 16'd1;
        end

        // A rise alone may still be the set-up for STOP/Sr; only a completed clock counts.
        if (scl_fall && nack_rise) begin
          ack_err   <= 1'b1;
          nack_pend <= 1'b0;
          nack_rise <= 1'b0;
        end

        if (scl_rise) begin
          case (state)
            ADDR: begin
              shift   <= rx_byte[6:0];
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (shift == SLAVE_ADDR) begin
                  state <= ADDR_ACK;
                  busy  <= 1'b1;
                  rw    <= sda_f;
                end else begin
                  state <= IGNORE;
                  busy  <= 1'b0;
                end
              end
            end
            ADDR_ACK: begin
              str_pend <= STR_EN;
              bit_cnt  <= '0;
              if (rw) begin
                state   <= RDATA;
                tx_byte <= regs[ptr];
              end else begin
                state <= PTR;
              end
            end
            PTR: begin
              shift   <= rx_byte[6:0];
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                state  <= PTR_ACK;
                ptr_ok <= ptr_in_range;
                if (ptr_in_range) ptr <= rx_byte[PTR_W-1:0];
              end
            end
            PTR_ACK: begin
              str_pend <= STR_EN;
              bit_cnt  <= '0;
              state    <= ptr_ok ? WDATA : IGNORE;
            end
            WDATA: begin
              shift   <= rx_byte[6:0];
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                state       <= WDATA_ACK;
                regs[ptr]   <= rx_byte;
                reg_wr_en   <= 1'b1;
                reg_wr_addr <= ptr;
                reg_wr_data <= rx_byte;
              end
            end
            WDATA_ACK: begin
              str_pend <= STR_EN;
              bit_cnt  <= '0;
              ptr      <= ptr_nxt;
              state    <= WDATA;
            end
            RDATA: begin
              tx_byte <= {tx_byte[6:0], 1'b0};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) state <= RDATA_ACK;
            end
            RDATA_ACK: begin
              str_pend <= STR_EN;
              bit_cnt  <= '0;
              ptr      <= ptr_nxt;
              if (!sda_f) begin
                state   <= RDATA;
                tx_byte <= regs[ptr_nxt];
              end else begin
                state     <= IGNORE;
                nack_pend <= 1'b1;
              end
            end
            IGNORE: begin
              if (nack_pend) nack_rise <= 1'b1;
            end
            default: begin
              state <= state;
            end
          endcase
        end
      end
    end
  end

endmodule
